// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key decoder: FSM states, element encodings and
// default timing/size parameters.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  localparam int unsigned DEF_MAX_ELEM   = 5;
  localparam int unsigned DEF_DASH_TICKS = 3;
  localparam int unsigned DEF_LETTER_GAP = 3;

endpackage

// File: rtl/morse_key_decoder_debounce.sv
// Key conditioner: 2-flop synchronizer followed by a stability filter; the output follows
// the synchronized key only after it has differed for DB_CYCLES consecutive clocks.
module morse_debounce #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;
  logic            dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      dout_q <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] != dout_q) begin
        if (cnt == DB_W'(DB_CYCLES - 1)) begin
          dout_q <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times presses/releases in divider ticks, classifies dot/dash and emits
// {code,len,err} on a valid/ready handshake. Key debounce enabled by `define MORSE_DEBOUNCE_EN.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DASH_TICKS = DEF_DASH_TICKS,
  parameter int unsigned LETTER_GAP = DEF_LETTER_GAP,
  parameter int unsigned MAX_ELEM   = DEF_MAX_ELEM,
  parameter int unsigned CNT_W      = 8
`ifdef MORSE_DEBOUNCE_EN
  , parameter int unsigned DB_CYCLES = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_in,
  input  logic                key_in,
  output logic [MAX_ELEM-1:0] sym_code,
  output logic [2:0]          sym_len,
  output logic                sym_err,
  output logic                sym_valid,
  input  logic                sym_ready,
  output logic                busy
);

  localparam logic [CNT_W-1:0] DASH_T = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_T  = CNT_W'(LETTER_GAP);
  localparam logic [2:0]       MAX_L  = 3'(MAX_ELEM);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc, cnt_gap;
  logic [MAX_ELEM-1:0] code, code_n;
  logic [2:0]          len, len_n;
  logic                err, err_n;
  logic                tick_q, tick_rise;
  logic                key_s;
  logic                elem;

`ifdef MORSE_DEBOUNCE_EN
  morse_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (key_in),
    .dout(key_s)
  );
`else
  logic key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= 1'b0;
    else     key_q <= key_in;
  end

  assign key_s = key_q;
`endif

  assign tick_rise = tick_in & ~tick_q;
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign cnt_gap   = tick_rise ? cnt_inc : cnt;
  assign elem      = (cnt >= DASH_T) ? ELEM_DASH : ELEM_DOT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      code   <= '0;
      len    <= '0;
      err    <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      code   <= code_n;
      len    <= len_n;
      err    <= err_n;
      tick_q <= tick_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = code;
    len_n   = len;
    err_n   = err;
    unique case (state)
      ST_IDLE: begin
        if (key_s) begin
          state_n = ST_PRESS;
          cnt_n   = '0;
        end
      end
      ST_PRESS: begin
        // Release wins over a same-cycle tick, so that tick is never counted.
        if (!key_s) begin
          if (len < MAX_L) begin
            code_n = code | (MAX_ELEM'(elem) << len);
            len_n  = len + 3'd1;
          end else begin
            err_n = 1'b1;
          end
          state_n = ST_GAP;
          cnt_n   = '0;
        end else if (tick_rise) begin
          cnt_n = cnt_inc;
        end
      end
      ST_GAP: begin
        // Gap completion is evaluated on the incremented count so EMIT follows the final tick directly.
        if (cnt_gap >= GAP_T) begin
          state_n = ST_EMIT;
          cnt_n   = '0;
        end else if (key_s) begin
          state_n = ST_PRESS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_gap;
        end
      end
      ST_EMIT: begin
        if (sym_ready) begin
          state_n = ST_IDLE;
          code_n  = '0;
          len_n   = '0;
          err_n   = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign sym_code  = code;
  assign sym_len   = len;
  assign sym_err   = err;
  assign sym_valid = (state == ST_EMIT);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Self-checking bench for morse_key_decoder: table of letters scored through a queue,
// plus hand-written sequences for backpressure, mid-letter reset and key glitches.
module tb_morse_key_decoder;

`ifdef MORSE_DEBOUNCE_EN
  localparam int KEY_LAT = 16 + 4;
`else
  localparam int KEY_LAT = 3;
`endif

  typedef struct packed {
    logic [4:0] code;
    logic [2:0] len;
    logic       err;
  } sym_t;

  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][3:0] dur;
    sym_t            exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       key_in = 1'b0;
  logic       sym_ready = 1'b1;
  logic [4:0] sym_code;
  logic [2:0] sym_len;
  logic       sym_err;
  logic       sym_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  sym_t scb[$];
  vec_t vecs[7];

  morse_key_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .key_in   (key_in),
    .sym_code (sym_code),
    .sym_len  (sym_len),
    .sym_err  (sym_err),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int d0, input int d1, input int d2,
                              input int d3, input int d4, input int d5,
                              input logic [4:0] code, input int len, input logic err);
    vec_t v;
    v          = '0;
    v.n        = 4'(n);
    v.dur[0]   = 4'(d0);
    v.dur[1]   = 4'(d1);
    v.dur[2]   = 4'(d2);
    v.dur[3]   = 4'(d3);
    v.dur[4]   = 4'(d4);
    v.dur[5]   = 4'(d5);
    v.exp.code = code;
    v.exp.len  = 3'(len);
    v.exp.err  = err;
    return v;
  endfunction

  // Scoreboard: every accepted symbol is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && sym_valid && sym_ready) begin
      hs_count++;
      if (scb.size() == 0) begin
        chk("unexpected_symbol", {23'd0, sym_code, sym_len, sym_err}, 32'hFFFF_FFFF);
      end else begin
        sym_t e;
        e = scb.pop_front();
        chk("sym_code", 32'(sym_code), 32'(e.code));
        chk("sym_len",  32'(sym_len),  32'(e.len));
        chk("sym_err",  32'(sym_err),  32'(e.err));
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    clk_n(2);
    tick_in = 1'b0;
    clk_n(2);
  endtask

  task automatic press(input int ticks);
    key_in = 1'b1;
    clk_n(KEY_LAT);
    repeat (ticks) tick_pulse();
    key_in = 1'b0;
    clk_n(KEY_LAT);
  endtask

  task automatic wait_accept(input string name, input int hs0);
    int k;
    k = 0;
    while (hs_count == hs0 && k < 60) begin
      clk_n(1);
      k++;
    end
    if (hs_count == hs0) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      if (scb.size() > 0) void'(scb.pop_back());
    end
  endtask

  task automatic send_letter(input vec_t v, input string name);
    int hs0;
    hs0 = hs_count;
    scb.push_back(v.exp);
    for (int i = 0; i < int'(v.n); i++) begin
      press(int'(v.dur[i]));
      if (i < int'(v.n) - 1) tick_pulse();
    end
    repeat (3) tick_pulse();
    wait_accept(name, hs0);
  endtask

  initial begin
    vecs[0] = mk(1, 1, 0, 0, 0, 0, 0, 5'b00000, 1, 1'b0);
    vecs[1] = mk(3, 4, 1, 5, 0, 0, 0, 5'b00101, 3, 1'b0);
    vecs[2] = mk(6, 1, 1, 1, 1, 1, 1, 5'b00000, 5, 1'b1);
    vecs[3] = mk(4, 3, 0, 2, 3, 0, 0, 5'b01001, 4, 1'b0);
    vecs[4] = mk(2, 2, 3, 0, 0, 0, 0, 5'b00010, 2, 1'b0);
    vecs[5] = mk(5, 3, 3, 3, 3, 3, 0, 5'b11111, 5, 1'b0);
    vecs[6] = mk(6, 3, 3, 3, 3, 3, 3, 5'b11111, 5, 1'b1);

    #2;
    chk("rst_valid", 32'(sym_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_code",  32'(sym_code),  32'd0);
    chk("rst_len",   32'(sym_len),   32'd0);
    chk("rst_err",   32'(sym_err),   32'd0);
    clk_n(3);
    rst = 1'b0;
    clk_n(2);

    for (int i = 0; i < 7; i++) send_letter(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: symbol held for 50 clocks while the key and tick toggle.
    begin
      sym_t snap;
      int   k;
      logic bad;
      sym_ready = 1'b0;
      press(1);
      repeat (3) tick_pulse();
      k = 0;
      while (!sym_valid && k < 40) begin
        clk_n(1);
        k++;
      end
      chk("hold_valid", 32'(sym_valid), 32'd1);
      snap = {sym_code, sym_len, sym_err};
      bad  = 1'b0;
      for (int i = 0; i < 50; i++) begin
        key_in  = ((i / 5) % 2) == 1;
        tick_in = (i % 4) < 2;
        @(negedge clk);
        if (!sym_valid || {sym_code, sym_len, sym_err} != snap) bad = 1'b1;
        @(posedge clk);
        #1;
      end
      chk("hold_stable", 32'(bad), 32'd0);
      key_in  = 1'b0;
      tick_in = 1'b0;
      clk_n(KEY_LAT + 2);
      scb.push_back('{code: 5'b00000, len: 3'd1, err: 1'b0});
      sym_ready = 1'b1;
      clk_n(1);
      chk("accept_valid_drop", 32'(sym_valid), 32'd0);
      chk("accept_busy",       32'(busy),      32'd0);
      if (scb.size() > 0) begin
        chk("accept_missing", 32'(scb.size()), 32'd0);
        scb.delete();
      end
    end

    // Reset while in PRESS after two recorded elements.
    press(1);
    tick_pulse();
    press(1);
    tick_pulse();
    key_in = 1'b1;
    clk_n(KEY_LAT);
    tick_pulse();
    chk("pre_rst_len",  32'(sym_len), 32'd2);
    chk("pre_rst_busy", 32'(busy),    32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(sym_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_code",  32'(sym_code),  32'd0);
    chk("mid_rst_len",   32'(sym_len),   32'd0);
    chk("mid_rst_err",   32'(sym_err),   32'd0);
    key_in = 1'b0;
    clk_n(KEY_LAT + 2);
    rst = 1'b0;
    clk_n(2);
    send_letter(vecs[0], "post_rst");

    // Short key glitch.
    begin
      int hs0;
      hs0 = hs_count;
`ifdef MORSE_DEBOUNCE_EN
      key_in = 1'b1;
      clk_n(5);
      key_in = 1'b0;
      clk_n(KEY_LAT + 10);
      chk("glitch_busy", 32'(busy), 32'd0);
      repeat (3) tick_pulse();
      chk("glitch_no_symbol", 32'(hs_count - hs0), 32'd0);
`else
      scb.push_back('{code: 5'b00000, len: 3'd1, err: 1'b0});
      key_in = 1'b1;
      clk_n(5);
      key_in = 1'b0;
      clk_n(KEY_LAT);
      repeat (3) tick_pulse();
      wait_accept("glitch_dot", hs0);
`endif
    end

    clk_n(5);
    if (scb.size() != 0) chk("scb_leftover", 32'(scb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
